csr_exec_unit: RTL and testbench
================================

CSR_EXEC_UNIT -- requirements
Module: csr_exec_unit

Interface
REQ-001 SHALL have parameter CSR_WIDTH, default 32, meaning width of all CSR data paths.
REQ-002 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-003 SHALL have ports: in_valid in 1 request valid; in_ready out 1 unit can accept; csr_op in 3 funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI); csr_addr in 12; rs1_data in 32; zimm in 5; pc in 32; is_ecall in 1; is_mret in 1.
REQ-004 SHALL have ports: mepc_in, mcause_in, mstatus_in, mtvec_in, mvendorid_in, marchid_in, each in 32, current CSR file values.
REQ-005 SHALL have ports: csrd out 32 write data; csr_wen out 4 (bit0 mepc, bit1 mcause, bit2 mstatus, bit3 mtvec); ecall_flag out 1.
REQ-006 SHALL have ports: out_valid out 1; out_ready in 1; rd_data out 32 old CSR value; illegal out 1; redirect_valid out 1; redirect_pc out 32.

Function
REQ-007 SHALL use FSM states IDLE, EXEC, RESP, TRAP, REDIR (plus ILL_EPC, ILL_CAUSE under CSR_ILLEGAL_TRAP_EN); in_ready=1 only in IDLE.
REQ-008 SHALL register all request fields on in_valid&&in_ready; priority is_ecall > is_mret > CSR op.
REQ-009 SHALL map addresses 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0xF11 mvendorid, 0xF12 marchid; other addresses illegal.
REQ-010 CSR op: IDLE->EXEC; in EXEC SHALL compute new value from registered old value: RW src, RS old|src, RC old&~src; src = rs1_data or zero-extended zimm for I-forms.
REQ-011 SHALL assert exactly one csr_wen bit for exactly the EXEC cycle, csrd=new value; no write for RS/RC/RSI/RCI when src==0.
REQ-012 Write attempt to 0xF11/0xF12 or any access to an unmapped address SHALL be illegal: csr_wen=0, illegal=1, rd_data=0.
REQ-013 EXEC->RESP; RESP SHALL hold out_valid, rd_data, illegal stable until out_ready, then ->IDLE; total latency request->out_valid = 2 cycles.
REQ-014 ECALL: IDLE->TRAP; TRAP SHALL assert ecall_flag for one cycle with csr_wen=0 (CSR file latches pc and cause 11), then ->REDIR.
REQ-015 MRET: IDLE->REDIR directly.
REQ-016 REDIR SHALL assert redirect_valid for exactly one cycle, redirect_pc = mtvec_in after ECALL/illegal trap, mepc_in after MRET; then ->IDLE; out_valid not asserted for ECALL/MRET.
REQ-017 Illegal fields and unused csr_op encodings (000, 100) SHALL be treated as illegal.

Reset
REQ-018 Reset SHALL force IDLE asynchronously, including mid-operation; pending request discarded, no partial write completes.
REQ-019 Reset values: in_ready=1 once reset deasserts; csrd=0, csr_wen=0, ecall_flag=0, out_valid=0, rd_data=0, illegal=0, redirect_valid=0, redirect_pc=0.

Configuration
REQ-020 Macro CSR_ILLEGAL_TRAP_EN: when defined, an illegal access SHALL go EXEC->ILL_EPC (csr_wen=0001, csrd=pc)->ILL_CAUSE (csr_wen=0010, csrd=2)->REDIR to mtvec_in, with no RESP/out_valid.
REQ-021 Without CSR_ILLEGAL_TRAP_EN, illegal access SHALL complete via RESP with illegal=1 and no trap.

Structure
REQ-022 Shared package SHALL hold the CSR address constants, csr_op encoding enum, csr_wen bit indices, FSM state enum, and cause codes (11 ECALL_M, 2 ILLEGAL_INST).
REQ-023 One sub-module csr_alu (combinational RW/RS/RC and write-suppression) is natural; the FSM stays in csr_exec_unit.

Verification
REQ-024 CSRRW 0x305, rs1_data=0x8000_0100, mtvec_in=0 -> EXEC cycle csr_wen=1000, csrd=0x8000_0100; RESP rd_data=0.
REQ-025 CSRRS 0x300, rs1_data=0, mstatus_in=0x1800 -> csr_wen stays 0000; rd_data=0x1800.
REQ-026 ECALL pc=0x0000_0040, mtvec_in=0x100 -> one-cycle ecall_flag, then redirect_valid with redirect_pc=0x100; in_ready=0 throughout.
REQ-027 MRET mepc_in=0x44 -> redirect_valid next cycle, redirect_pc=0x44.
REQ-028 CSRRW 0xF11 -> without macro: illegal=1, csr_wen=0; with CSR_ILLEGAL_TRAP_EN: csr_wen 0001 (csrd=pc) then 0010 (csrd=2), then redirect to mtvec_in.
REQ-029 Reset asserted during EXEC of a CSRRW -> csr_wen drops to 0 immediately, FSM in IDLE, out_valid=0 after release.

Source files
------------

// File: rtl/csr_exec_unit_pkg.sv
// Shared definitions for the CSR execution unit: CSR addresses, funct3 op
// encodings, write-enable bit positions, FSM states and trap cause codes.
package csr_exec_unit_pkg;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;

    localparam int unsigned WEN_MEPC    = 0;
    localparam int unsigned WEN_MCAUSE  = 1;
    localparam int unsigned WEN_MSTATUS = 2;
    localparam int unsigned WEN_MTVEC   = 3;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        RESP,
        TRAP,
        REDIR
`ifdef CSR_ILLEGAL_TRAP_EN
        , ILL_EPC,
        ILL_CAUSE
`endif
    } state_e;

    localparam int unsigned CAUSE_ECALL_M      = 11;
    localparam int unsigned CAUSE_ILLEGAL_INST = 2;

endpackage

// File: rtl/csr_alu.sv
// Combinational CSR read-modify-write: computes the new value for RW/RS/RC
// forms, picks the write-enable bit, and flags illegal ops or addresses.
module csr_alu
    import csr_exec_unit_pkg::*;
#(
    parameter int CSR_WIDTH = 32
) (
    input  logic [2:0]           op_i,
    input  logic [11:0]          addr_i,
    input  logic [CSR_WIDTH-1:0] src_i,
    input  logic [CSR_WIDTH-1:0] old_i,
    output logic [CSR_WIDTH-1:0] new_val_o,
    output logic [3:0]           wen_o,
    output logic                 illegal_o
);

    logic       write;
    logic       op_ok;
    logic       mapped;
    logic       read_only;
    logic [3:0] sel;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no path leaves one unassigned (no latches).
        new_val_o = old_i;
        write     = 1'b0;
        op_ok     = 1'b1;
        mapped    = 1'b1;
        read_only = 1'b0;
        sel       = '0;

        case (op_i)
            CSR_RW, CSR_RWI: begin
                new_val_o = src_i;
                write     = 1'b1;
            end
            CSR_RS, CSR_RSI: begin
                new_val_o = old_i | src_i;
                write     = (src_i != '0);
            end
            CSR_RC, CSR_RCI: begin
                new_val_o = old_i & ~src_i;
                write     = (src_i != '0);
            end
            default: op_ok = 1'b0;
        endcase

        case (addr_i)
            ADDR_MSTATUS:                 sel[WEN_MSTATUS] = 1'b1;
            ADDR_MTVEC:                   sel[WEN_MTVEC]   = 1'b1;
            ADDR_MEPC:                    sel[WEN_MEPC]    = 1'b1;
            ADDR_MCAUSE:                  sel[WEN_MCAUSE]  = 1'b1;
            ADDR_MVENDORID, ADDR_MARCHID: read_only        = 1'b1;
            default:                      mapped           = 1'b0;
        endcase

        // A set/clear with a zero source is a pure read, so it is legal on read-only CSRs.
        illegal_o = !op_ok || !mapped || (read_only && write);
        wen_o     = (write && !illegal_o) ? sel : 4'b0000;
    end

endmodule

// File: rtl/csr_exec_unit.sv
// Multi-cycle CSR execution unit: CSR read-modify-write, ECALL trap entry and
// MRET return. Define CSR_ILLEGAL_TRAP_EN to turn illegal accesses into traps.
module csr_exec_unit
    import csr_exec_unit_pkg::*;
#(
    parameter int CSR_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           csr_op,
    input  logic [11:0]          csr_addr,
    input  logic [CSR_WIDTH-1:0] rs1_data,
    input  logic [4:0]           zimm,
    input  logic [CSR_WIDTH-1:0] pc,
    input  logic                 is_ecall,
    input  logic                 is_mret,
    input  logic [CSR_WIDTH-1:0] mepc_in,
    input  logic [CSR_WIDTH-1:0] mcause_in,
    input  logic [CSR_WIDTH-1:0] mstatus_in,
    input  logic [CSR_WIDTH-1:0] mtvec_in,
    input  logic [CSR_WIDTH-1:0] mvendorid_in,
    input  logic [CSR_WIDTH-1:0] marchid_in,
    output logic [CSR_WIDTH-1:0] csrd,
    output logic [3:0]           csr_wen,
    output logic                 ecall_flag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CSR_WIDTH-1:0] rd_data,
    output logic                 illegal,
    output logic                 redirect_valid,
    output logic [CSR_WIDTH-1:0] redirect_pc
);

    state_e               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [11:0]          addr_q, addr_d;
    logic [CSR_WIDTH-1:0] src_q, src_d;
    logic [CSR_WIDTH-1:0] old_q, old_d;
    logic [CSR_WIDTH-1:0] pc_q, pc_d;
    logic                 ret_mepc_q, ret_mepc_d;

    logic [CSR_WIDTH-1:0] csr_old;
    logic [CSR_WIDTH-1:0] alu_new;
    logic [3:0]           alu_wen;
    logic                 alu_illegal;

    always_comb begin
        csr_old = '0;
        case (csr_addr)
            ADDR_MSTATUS:   csr_old = mstatus_in;
            ADDR_MTVEC:     csr_old = mtvec_in;
            ADDR_MEPC:      csr_old = mepc_in;
            ADDR_MCAUSE:    csr_old = mcause_in;
            ADDR_MVENDORID: csr_old = mvendorid_in;
            ADDR_MARCHID:   csr_old = marchid_in;
            default:        csr_old = '0;
        endcase
    end

    csr_alu #(.CSR_WIDTH(CSR_WIDTH)) u_alu (
        .op_i      (op_q),
        .addr_i    (addr_q),
        .src_i     (src_q),
        .old_i     (old_q),
        .new_val_o (alu_new),
        .wen_o     (alu_wen),
        .illegal_o (alu_illegal)
    );

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            old_q      <= '0;
            pc_q       <= '0;
            ret_mepc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            old_q      <= old_d;
            pc_q       <= pc_d;
            ret_mepc_q <= ret_mepc_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        src_d          = src_q;
        old_d          = old_q;
        pc_d           = pc_q;
        ret_mepc_d     = ret_mepc_q;
        in_ready       = 1'b0;
        csrd           = '0;
        csr_wen        = 4'b0000;
        ecall_flag     = 1'b0;
        out_valid      = 1'b0;
        rd_data        = '0;
        illegal        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d       = csr_op;
                    addr_d     = csr_addr;
                    src_d      = csr_op[2] ? CSR_WIDTH'(zimm) : rs1_data;
                    old_d      = csr_old;
                    pc_d       = pc;
                    ret_mepc_d = 1'b0;
                    if (is_ecall) begin
                        state_d = TRAP;
                    end else if (is_mret) begin
                        ret_mepc_d = 1'b1;
                        state_d    = REDIR;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                csr_wen = alu_wen;
                csrd    = (alu_wen != 4'b0000) ? alu_new : '0;
`ifdef CSR_ILLEGAL_TRAP_EN
                state_d = alu_illegal ? ILL_EPC : RESP;
`else
                state_d = RESP;
`endif
            end
            RESP: begin
                // Registered request fields are frozen here, so the ALU outputs stay stable.
                out_valid = 1'b1;
                rd_data   = alu_illegal ? '0 : old_q;
                illegal   = alu_illegal;
                if (out_ready) state_d = IDLE;
            end
            TRAP: begin
                ecall_flag = 1'b1;
                csrd       = pc_q;
                state_d    = REDIR;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = ret_mepc_q ? mepc_in : mtvec_in;
                state_d        = IDLE;
            end
`ifdef CSR_ILLEGAL_TRAP_EN
            ILL_EPC: begin
                csr_wen[WEN_MEPC] = 1'b1;
                csrd              = pc_q;
                state_d           = ILL_CAUSE;
            end
            ILL_CAUSE: begin
                csr_wen[WEN_MCAUSE] = 1'b1;
                csrd                = CSR_WIDTH'(CAUSE_ILLEGAL_INST);
                state_d             = REDIR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Randomized self-checking bench for csr_exec_unit against a spec-level model.
// Honours CSR_ILLEGAL_TRAP_EN when the design is built with it.
module tb_csr_exec_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic [31:0] pc;
    logic        is_ecall, is_mret;
    logic [31:0] mepc_in, mcause_in, mstatus_in, mtvec_in, mvendorid_in, marchid_in;
    logic [31:0] csrd;
    logic [3:0]  csr_wen;
    logic        ecall_flag, out_valid, out_ready;
    logic [31:0] rd_data;
    logic        illegal, redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_pass   = 0;

    csr_exec_unit #(.CSR_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .csr_op(csr_op), .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm),
        .pc(pc), .is_ecall(is_ecall), .is_mret(is_mret),
        .mepc_in(mepc_in), .mcause_in(mcause_in), .mstatus_in(mstatus_in),
        .mtvec_in(mtvec_in), .mvendorid_in(mvendorid_in), .marchid_in(marchid_in),
        .csrd(csrd), .csr_wen(csr_wen), .ecall_flag(ecall_flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd_data(rd_data), .illegal(illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Spec-level model: outcome of one CSR instruction given the current CSR file.
    function automatic void model(input logic [2:0] op, input logic [11:0] addr,
                                  input logic [31:0] rs1, input logic [4:0] z,
                                  output logic ill, output logic [3:0] wen,
                                  output logic [31:0] newv, output logic [31:0] rd);
        logic [31:0] src, oldv;
        bit writes, mapped, ro;
        int slot;
        src    = (op inside {3'b101, 3'b110, 3'b111}) ? {27'b0, z} : rs1;
        slot   = -1;
        mapped = 1;
        ro     = 0;
        oldv   = 0;
        case (addr)
            12'h341: begin oldv = mepc_in;      slot = 0; end
            12'h342: begin oldv = mcause_in;    slot = 1; end
            12'h300: begin oldv = mstatus_in;   slot = 2; end
            12'h305: begin oldv = mtvec_in;     slot = 3; end
            12'hF11: begin oldv = mvendorid_in; ro = 1;   end
            12'hF12: begin oldv = marchid_in;   ro = 1;   end
            default: mapped = 0;
        endcase
        writes = (op == 3'b001) || (op == 3'b101) || (src != 0);
        case (op[1:0])
            2'd1:    newv = src;
            2'd2:    newv = oldv | src;
            2'd3:    newv = oldv & ~src;
            default: newv = 0;
        endcase
        ill = !mapped || (op[1:0] == 2'd0) || (ro && writes);
        wen = (!ill && writes && slot >= 0) ? 4'(1 << slot) : 4'b0000;
        rd  = ill ? 32'h0 : oldv;
    endfunction

    task automatic randomize_csr_file();
        mepc_in      = $urandom;
        mcause_in    = $urandom;
        mstatus_in   = $urandom;
        mtvec_in     = $urandom;
        mvendorid_in = $urandom;
        marchid_in   = $urandom;
    endtask

    task automatic scramble_inputs();
        csr_op   = 3'($urandom);
        csr_addr = 12'($urandom);
        rs1_data = $urandom;
        zimm     = 5'($urandom);
        pc       = $urandom;
        is_ecall = 1'($urandom);
        is_mret  = 1'($urandom);
    endtask

    task automatic drive_req(input logic ec, input logic mr, input logic [2:0] op,
                             input logic [11:0] addr, input logic [31:0] rs1,
                             input logic [4:0] z, input logic [31:0] pcv);
        @(negedge clock);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        is_ecall = ec;
        is_mret  = mr;
        csr_op   = op;
        csr_addr = addr;
        rs1_data = rs1;
        zimm     = z;
        pc       = pcv;
        @(negedge clock);
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic run_csr(input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] rs1, input logic [4:0] z, input logic [31:0] pcv);
        logic ill;
        logic [3:0] wen;
        logic [31:0] newv, rd;
        int stall;
        model(op, addr, rs1, z, ill, wen, newv, rd);
        drive_req(1'b0, 1'b0, op, addr, rs1, z, pcv);
        check("exec_wen", csr_wen, wen);
        check("exec_csrd", csrd, (wen != 0) ? newv : 32'h0);
        check("exec_in_ready", in_ready, 0);
        check("exec_out_valid", out_valid, 0);
`ifdef CSR_ILLEGAL_TRAP_EN
        if (ill) begin
            @(negedge clock);
            check("ill_epc_wen", csr_wen, 4'b0001);
            check("ill_epc_csrd", csrd, pcv);
            @(negedge clock);
            check("ill_cause_wen", csr_wen, 4'b0010);
            check("ill_cause_csrd", csrd, 32'd2);
            @(negedge clock);
            check("ill_redir_valid", redirect_valid, 1);
            check("ill_redir_pc", redirect_pc, mtvec_in);
            check("ill_no_out_valid", out_valid, 0);
            @(negedge clock);
            check("ill_redir_one_cycle", redirect_valid, 0);
            return;
        end
`endif
        @(negedge clock);
        check("resp_out_valid", out_valid, 1);
        check("resp_rd_data", rd_data, rd);
        check("resp_illegal", illegal, ill);
        check("resp_wen_idle", csr_wen, 0);
        stall = $urandom_range(0, 2);
        repeat (stall) begin
            @(negedge clock);
            check("stall_out_valid", out_valid, 1);
            check("stall_rd_data", rd_data, rd);
            check("stall_illegal", illegal, ill);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("post_resp_out_valid", out_valid, 0);
        check("post_resp_in_ready", in_ready, 1);
    endtask

    task automatic run_ecall(input logic [31:0] pcv, input logic with_mret);
        drive_req(1'b1, with_mret, 3'($urandom), 12'($urandom), $urandom, 5'($urandom), pcv);
        check("trap_ecall_flag", ecall_flag, 1);
        check("trap_wen", csr_wen, 0);
        check("trap_in_ready", in_ready, 0);
        check("trap_redir_valid", redirect_valid, 0);
        @(negedge clock);
        check("ecall_redir_valid", redirect_valid, 1);
        check("ecall_redir_pc", redirect_pc, mtvec_in);
        check("ecall_flag_one_cycle", ecall_flag, 0);
        check("ecall_redir_in_ready", in_ready, 0);
        @(negedge clock);
        check("ecall_redir_done", redirect_valid, 0);
        check("ecall_no_out_valid", out_valid, 0);
        check("ecall_back_idle", in_ready, 1);
    endtask

    task automatic run_mret();
        drive_req(1'b0, 1'b1, 3'($urandom), 12'($urandom), $urandom, 5'($urandom), $urandom);
        check("mret_redir_valid", redirect_valid, 1);
        check("mret_redir_pc", redirect_pc, mepc_in);
        check("mret_wen", csr_wen, 0);
        check("mret_in_ready", in_ready, 0);
        @(negedge clock);
        check("mret_redir_done", redirect_valid, 0);
        check("mret_no_out_valid", out_valid, 0);
        check("mret_back_idle", in_ready, 1);
    endtask

    localparam logic [11:0] ADDRS [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        scramble_inputs();
        randomize_csr_file();

        @(negedge clock);
        check("rst_wen", csr_wen, 0);
        check("rst_csrd", csrd, 0);
        check("rst_ecall_flag", ecall_flag, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_illegal", illegal, 0);
        check("rst_redir_valid", redirect_valid, 0);
        check("rst_redir_pc", redirect_pc, 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", in_ready, 1);

        // Directed scenarios.
        mtvec_in = 32'h0;
        run_csr(3'b001, 12'h305, 32'h8000_0100, 5'd0, 32'h1000);
        mstatus_in = 32'h1800;
        run_csr(3'b010, 12'h300, 32'h0, 5'd0, 32'h1004);
        mtvec_in = 32'h100;
        run_ecall(32'h0000_0040, 1'b0);
        mepc_in = 32'h44;
        run_mret();
        run_csr(3'b001, 12'hF11, 32'h1234_5678, 5'd0, 32'h2000);
        run_csr(3'b010, 12'hF12, 32'h0, 5'd0, 32'h2004);
        run_csr(3'b110, 12'hF11, 32'hFFFF_FFFF, 5'd0, 32'h2008);
        run_csr(3'b000, 12'h300, 32'h5, 5'd0, 32'h200C);
        run_csr(3'b100, 12'h341, 32'h5, 5'd3, 32'h2010);
        run_csr(3'b011, 12'h301, 32'h0, 5'd0, 32'h2014);
        run_csr(3'b111, 12'h342, 32'hFFFF_FFFF, 5'h1F, 32'h2018);
        run_csr(3'b101, 12'h341, 32'hDEAD_BEEF, 5'h15, 32'h201C);
        run_ecall(32'h0000_0080, 1'b1);

        // Reset during EXEC of a CSRRW.
        mepc_in = 32'h0;
        drive_req(1'b0, 1'b0, 3'b001, 12'h341, 32'hCAFE_0001, 5'd0, 32'h3000);
        check("pre_rst_exec_wen", csr_wen, 4'b0001);
        reset = 1'b1;
        #1;
        check("mid_rst_wen", csr_wen, 0);
        check("mid_rst_csrd", csrd, 0);
        @(negedge clock);
        reset = 1'b0;
        check("rel_rst_in_ready", in_ready, 1);
        @(negedge clock);
        check("rel_rst_out_valid", out_valid, 0);
        check("rel_rst_wen", csr_wen, 0);
        check("rel_rst_in_ready2", in_ready, 1);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            int kind;
            logic [11:0] a;
            randomize_csr_file();
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : ADDRS[$urandom_range(0, 5)];
            if (kind == 0) run_ecall($urandom, 1'($urandom));
            else if (kind == 1) run_mret();
            else run_csr(3'($urandom), a,
                         ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                         ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                         $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
